// File: rtl/sort_frame_loader.sv
// sort_frame_loader: upstream feeder for the bitonic sorter.
// Collects WIDTH-bit beats into a DEPTH-entry frame and presents the frame as
// an unpacked vector with a one-cycle valid pulse. Short frames are padded
// with PAD_VALUE so pad slots sort to the top of an ascending result.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   s_valid      input beat valid
//   s_ready      loader can accept a beat (registered, 0 during reset)
//   s_data       input word
//   s_last       final beat of a frame
//   frame_out    assembled frame (sorter `unsorted`)
//   frame_valid  one-cycle pulse (sorter `valid_in`)
//   frame_count  number of real words in frame_out, 1..DEPTH
//   overflow_err one-cycle pulse when a frame exceeds DEPTH beats
module sort_frame_loader #(
  parameter int                 WIDTH     = 32,
  parameter int                 DEPTH     = 8,
  parameter logic [WIDTH-1:0]   PAD_VALUE = '1,
  localparam int                CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic [WIDTH-1:0] frame_out [DEPTH-1:0],
  output logic             frame_valid,
  output logic [CW-1:0]    frame_count,
  output logic             overflow_err
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic {
    COLLECT,
    DRAIN
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] buf_q      [DEPTH-1:0];
  logic [WIDTH-1:0] frame_next [DEPTH-1:0];
  logic             accept;
  logic             last_slot;

  assign accept    = s_valid && s_ready;
  assign last_slot = (idx == IW'(DEPTH - 1));

  // The completing beat bypasses the buffer: slots below idx come from the
  // buffer, slot idx takes s_data directly, slots above idx take the pad.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      frame_next[i] = PAD_VALUE;
      if (i < 32'(idx))
        frame_next[i] = buf_q[i];
      else if (i == 32'(idx))
        frame_next[i] = s_data;
    end
  end

  // Buffer contents need no reset: slots are always written before being
  // read back into frame_out.
  always_ff @(posedge clk) begin
    if (!rst && accept && state == COLLECT)
      buf_q[idx] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= COLLECT;
      idx          <= '0;
      s_ready      <= 1'b0;
      frame_valid  <= 1'b0;
      overflow_err <= 1'b0;
      frame_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++)
        frame_out[i] <= '0;
    end else begin
      s_ready      <= 1'b1;
      frame_valid  <= 1'b0;
      overflow_err <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept) begin
            if (s_last || last_slot) begin
              frame_out   <= frame_next;
              frame_count <= CW'(idx) + CW'(1);
              frame_valid <= 1'b1;
              idx         <= '0;
              if (!s_last) begin
                overflow_err <= 1'b1;
                state        <= DRAIN;
              end
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        DRAIN: begin
          if (accept && s_last)
            state <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_frame_loader.sv
module tb_sort_frame_loader;

  localparam int W = 32;
  localparam int D = 8;
  localparam logic [W-1:0] P = '1;

  typedef logic [W-1:0] frame_t [D];

  typedef struct {
    bit          r;
    bit          v;
    logic [W-1:0] d;
    bit          l;
    bit          rdy;
    bit          fv;
    bit          ovf;
    bit          upd;
    int          cnt;
    frame_t      fr;
  } vec_t;

  vec_t vq[$];

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_data = '0;
  logic         s_last = 1'b0;
  logic [W-1:0] frame_out [D-1:0];
  logic         frame_valid;
  logic [3:0]   frame_count;
  logic         overflow_err;

  int     n_cmp = 0;
  int     n_bad = 0;
  frame_t exp_fr;
  int     exp_cnt;

  always #5 clk = ~clk;

  sort_frame_loader #(.WIDTH(W), .DEPTH(D), .PAD_VALUE(P)) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .frame_out(frame_out),
    .frame_valid(frame_valid),
    .frame_count(frame_count),
    .overflow_err(overflow_err)
  );

  function automatic void push(bit r, bit v, logic [W-1:0] d, bit l,
                               bit rdy, bit fv, bit ovf);
    vec_t e;
    e.r = r; e.v = v; e.d = d; e.l = l;
    e.rdy = rdy; e.fv = fv; e.ovf = ovf;
    e.upd = 1'b0; e.cnt = 0;
    for (int i = 0; i < D; i++) e.fr[i] = '0;
    vq.push_back(e);
  endfunction

  // Beat whose edge completes a frame: frame_valid and new contents expected.
  function automatic void push_f(logic [W-1:0] d, bit l, bit ovf, int cnt,
                                 frame_t f);
    vec_t e;
    e.r = 1'b0; e.v = 1'b1; e.d = d; e.l = l;
    e.rdy = 1'b1; e.fv = 1'b1; e.ovf = ovf;
    e.upd = 1'b1; e.cnt = cnt; e.fr = f;
    vq.push_back(e);
  endfunction

  function automatic void beat(logic [W-1:0] d, bit l);
    push(1'b0, 1'b1, d, l, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic void idle();
    push(1'b0, 1'b0, 32'd99, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(bit rdy, bit fv, bit ovf);
    chk("s_ready", W'(s_ready), W'(rdy));
    chk("frame_valid", W'(frame_valid), W'(fv));
    chk("overflow_err", W'(overflow_err), W'(ovf));
    chk("frame_count", W'(frame_count), W'(exp_cnt));
    for (int i = 0; i < D; i++)
      chk($sformatf("frame_out[%0d]", i), frame_out[i], exp_fr[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    for (int i = 0; i < D; i++) exp_fr[i] = '0;
    exp_cnt = 0;

    // reset, then first cycle out of reset
    push(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    // full frame
    beat(10, 0); beat(3, 0); beat(25, 0); beat(7, 0);
    beat(1, 0); beat(18, 0); beat(2, 0);
    push_f(5, 1, 0, 8, '{10, 3, 25, 7, 1, 18, 2, 5});
    idle();
    // short frame
    beat(4, 0); beat(9, 0);
    push_f(1, 1, 0, 3, '{4, 9, 1, P, P, P, P, P});
    idle();
    // back-to-back full frames
    for (int i = 1; i <= 7; i++) beat(i, 0);
    push_f(8, 1, 0, 8, '{1, 2, 3, 4, 5, 6, 7, 8});
    for (int i = 8; i >= 2; i--) beat(i, 0);
    push_f(1, 1, 0, 8, '{8, 7, 6, 5, 4, 3, 2, 1});
    idle();
    // overflow: beats 8 and 9 drained, then a 2-beat frame
    for (int i = 0; i <= 6; i++) beat(i, 0);
    push_f(7, 0, 1, 8, '{0, 1, 2, 3, 4, 5, 6, 7});
    beat(8, 0);
    beat(9, 1);
    beat(5, 0);
    push_f(6, 1, 0, 2, '{5, 6, P, P, P, P, P, P});
    // gaps (junk s_last with s_valid low is ignored), then single-beat frame
    beat(7, 0); idle(); idle();
    push_f(3, 1, 0, 2, '{7, 3, P, P, P, P, P, P});
    push_f(42, 1, 0, 1, '{42, P, P, P, P, P, P, P});
    idle();
    // reset mid-frame; reset coincides with a would-be completing beat
    beat(11, 0); beat(12, 0); beat(13, 0);
    push(1'b1, 1'b1, 14, 1'b1, 1'b0, 1'b0, 1'b0);
    // s_ready still low: this beat must not be accepted
    push(1'b0, 1'b1, 77, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++) beat(i, 0);
    push_f(8, 1, 0, 8, '{1, 2, 3, 4, 5, 6, 7, 8});
    idle();

    for (int k = 0; k < vq.size(); k++) begin
      rst     = vq[k].r;
      s_valid = vq[k].v;
      s_data  = vq[k].d;
      s_last  = vq[k].l;
      tick();
      if (vq[k].r) begin
        for (int i = 0; i < D; i++) exp_fr[i] = '0;
        exp_cnt = 0;
      end else if (vq[k].upd) begin
        exp_fr  = vq[k].fr;
        exp_cnt = vq[k].cnt;
      end
      chk_outputs(vq[k].rdy, vq[k].fv, vq[k].ovf);
    end

    // latency measured with a bounded wait on frame_valid
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = W'(50 + i);
      s_last  = (i == 4);
      tick();
      if (i < 4) chk("frame_valid early", W'(frame_valid), '0);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    lat = 1;
    while (frame_valid !== 1'b1 && lat < 4) begin
      tick();
      lat++;
    end
    chk("completion latency", W'(lat), W'(1));
    exp_fr  = '{50, 51, 52, 53, 54, P, P, P};
    exp_cnt = 5;
    chk_outputs(1'b1, 1'b1, 1'b0);
    tick();
    chk_outputs(1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sort_frame_loader.md
# sort_frame_loader

Upstream feeder for the bitonic sorter `top`. It collects a stream of WIDTH-bit words, one beat per cycle, into a DEPTH-entry frame. It then presents the frame as an unpacked vector with a single-cycle valid pulse, which drives the sorter's `unsorted` / `valid_in`. Short frames are padded so that pad slots sort to the top of an ascending result.

## Interface
- WIDTH, 32, word width; must match the sorter's WIDTH.
- DEPTH, 8, words per frame; power of two, ≥2; must match the sorter's DEPTH.
- PAD_VALUE, {WIDTH{1'b1}}, value written to slots not filled by a short frame.
- CW, $clog2(DEPTH+1), width of frame_count; local parameter, not overridable.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  loader can accept a beat.
- s_data  in  WIDTH  input word.
- s_last  in  1  marks the final beat of a frame.
- frame_out  out  [WIDTH-1:0] x [DEPTH-1:0] unpacked  assembled frame; connects to the sorter's `unsorted`.
- frame_valid  out  1  one-cycle pulse; connects to the sorter's `valid_in`.
- frame_count  out  CW  number of real (non-pad) words in frame_out, 1..DEPTH.
- overflow_err  out  1  one-cycle pulse when a frame exceeds DEPTH beats.

## Operation
- Beat accepted = s_valid && s_ready. Beats are only accepted in that cycle; s_data and s_last are ignored otherwise.
- Internal state:
  - collection buffer, DEPTH x WIDTH;
  - slot index idx, width $clog2(DEPTH), range 0..DEPTH-1;
  - FSM with states COLLECT and DRAIN.
- Output registers: frame_out and frame_count are separate from the collection buffer. They are loaded only when a frame completes and hold their value until the next completion.
- COLLECT, for each accepted beat:
  - The beat is written to slot idx; the i-th beat of a frame lands in slot i.
  - If s_last=1 and idx<DEPTH-1 (short frame): frame_out gets buffer slots 0..idx-1, s_data in slot idx, and PAD_VALUE in slots idx+1..DEPTH-1. frame_count=idx+1, frame_valid=1 next cycle, idx←0, stay in COLLECT.
  - If idx==DEPTH-1 and s_last=1: full frame. frame_count=DEPTH, frame_valid=1 next cycle, idx←0, stay in COLLECT.
  - If idx==DEPTH-1 and s_last=0: full frame emitted as above, overflow_err=1 next cycle, go to DRAIN.
  - Otherwise: idx←idx+1.
- DRAIN:
  - s_ready=1; accepted beats are discarded.
  - Accepting a beat with s_last=1 returns the FSM to COLLECT with idx=0.
  - No frame_valid is produced for dropped beats.
- Width rules:
  - idx wraps only via the explicit ←0 on frame completion, never by natural overflow.
  - frame_count is zero-extended from idx+1 into CW bits; no truncation, since DEPTH fits in CW.

## Timing
- Reset values: s_ready=0, frame_valid=0, overflow_err=0, frame_count=0, frame_out all 0, idx=0, FSM=COLLECT.
- s_ready is registered. It is 0 while rst=1 and 1 from the first cycle after rst deasserts, in both states.
- No backpressure from the sorter; the loader never stalls once out of reset.
- Latency: frame_valid and the new frame_out/frame_count appear on the cycle after the completing beat is accepted.
- frame_valid and overflow_err are exactly one cycle wide.
- Back-to-back frames need no bubble. The first beat of frame N+1 may be accepted in the same cycle frame N's frame_valid is high.
- Minimum frame_valid spacing is 1 cycle (consecutive single-beat frames). The sorter must tolerate this rate.
- s_valid gaps mid-frame are allowed. idx and the buffer hold; there is no timeout.
- Reset mid-frame: the partial frame is discarded, no frame_valid is produced, and all outputs return to reset values on the next edge.
- Reset in the same cycle as a completing beat: reset wins, and no frame_valid is produced.

## Test plan
- Full frame: 10,3,25,7,1,18,2,5 on consecutive cycles, s_last on beat 8 -> one cycle later frame_valid=1 for 1 cycle, frame_out[0..7]=10,3,25,7,1,18,2,5, frame_count=8, overflow_err=0.
- Short frame: 4,9,1 with s_last on beat 3 -> frame_out=4,9,1,FFFFFFFF x5, frame_count=3. Feeding this into the sorter yields 1,4,9,FFFFFFFF x5.
- Back-to-back: two full frames with no idle cycle (1..8, then 8..1) -> two frame_valid pulses exactly 8 cycles apart, each with correct contents; s_ready stays 1 throughout.
- Overflow: 10 beats 0..9, s_last only on beat 10 -> frame 0..7 with frame_count=8, overflow_err pulse in the same cycle as frame_valid, beats 8 and 9 dropped. A following 2-beat frame 5,6 -> frame_out=5,6,FFFFFFFF x6.
- Gaps and single-beat frames: beats 7 _ _ 3 (s_last), then 42 (s_last) -> frame 7,3,pad x6 with frame_count=2, then frame 42,pad x7 with frame_count=1.
- Reset mid-frame: 3 beats, assert rst for 1 cycle, then a full frame 1..8 -> no output for the partial frame; s_ready=0 during reset; next frame_out=1..8 with frame_count=8.
